mmio_req_arbiter: RTL

- Shares the single SoC MMIO slave port (LED/switch and UART windows) between two requesters: the core data port (requester 0) and the debug/monitor port (requester 1).
- Each requester uses a req/ack handshake. The arbiter picks a winner by round-robin, latches its request, and issues exactly one MMIO access. It then returns read data with a one-cycle ack.
- Sits between the core/debug logic and the MMIO decoder.
- Guarantees stable addresses and single-cycle write strobes, because MMIO reads such as UART RX can have side effects.

---
 rtl/mmio_req_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mmio_req_arbiter.sv
// Round-robin arbiter sharing the MMIO slave port between the core (0) and debug (1) requesters.
// Optional grant counters are built when MMIO_REQ_ARBITER_STATS_EN is defined.
module mmio_req_arbiter #(
  parameter int unsigned ADDR_W = 29,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clkrst_core_clk,
  input  logic                clkrst_core_rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] wren0,
  input  logic [DATA_W/8-1:0] wren1,
  output logic                ack0,
  output logic                ack1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
  output logic [ADDR_W-1:0]   mmio_addr,
  output logic [DATA_W-1:0]   mmio_data_in,
  output logic [DATA_W/8-1:0] mmio_wren,
  output logic                mmio_rd,
  input  logic [DATA_W-1:0]   mmio_data_out,
  output logic [15:0]         stat_grants0,
  output logic [15:0]         stat_grants1
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_last_grant;
  logic                r_cur;
  logic [ADDR_W-1:0]   r_mmio_addr;
  logic [DATA_W-1:0]   r_mmio_data_in;
  logic [BE_W-1:0]     r_wren_q;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                w_grant;
  logic                w_win;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win       = 1'b0;
    case (r_state)
      StIdle: begin
        if (req0 || req1) begin
          w_grant     = 1'b1;
          // On a tie the requester that did not win last time goes first.
          w_win       = (req0 && req1) ? ~r_last_grant : req1;
          w_state_nxt = StIssue;
        end
      end
      StIssue: w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      r_state        <= StIdle;
      r_last_grant   <= 1'b1;
      r_cur          <= 1'b0;
      r_mmio_addr    <= '0;
      r_mmio_data_in <= '0;
      r_wren_q       <= '0;
      r_rdata0       <= '0;
      r_rdata1       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_cur          <= w_win;
        r_last_grant   <= w_win;
        r_mmio_addr    <= w_win ? addr1 : addr0;
        r_mmio_data_in <= w_win ? wdata1 : wdata0;
        r_wren_q       <= w_win ? wren1 : wren0;
      end
      if (r_state == StIssue) begin
        if (r_cur) r_rdata1 <= mmio_data_out;
        else       r_rdata0 <= mmio_data_out;
      end
    end
  end

  // Strobes exist only in ISSUE so side-effecting reads fire exactly once.
  assign mmio_wren    = (r_state == StIssue) ? r_wren_q : '0;
  assign mmio_rd      = (r_state == StIssue) && (r_wren_q == '0);
  assign ack0         = (r_state == StResp) && !r_cur;
  assign ack1         = (r_state == StResp) && r_cur;
  assign mmio_addr    = r_mmio_addr;
  assign mmio_data_in = r_mmio_data_in;
  assign rdata0       = r_rdata0;
  assign rdata1       = r_rdata1;

`ifdef MMIO_REQ_ARBITER_STATS_EN
  logic [15:0] r_grants0;
  logic [15:0] r_grants1;

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      r_grants0 <= '0;
      r_grants1 <= '0;
    end else if (w_grant) begin
      if (!w_win && (r_grants0 != 16'hFFFF)) r_grants0 <= r_grants0 + 16'd1;
      if (w_win && (r_grants1 != 16'hFFFF))  r_grants1 <= r_grants1 + 16'd1;
    end
  end

  assign stat_grants0 = r_grants0;
  assign stat_grants1 = r_grants1;
`else
  assign stat_grants0 = '0;
  assign stat_grants1 = '0;
`endif

endmodule
